// File: rtl/button_pkg.sv
// Shared types and default timing constants for the push-button input path.
// Used by the debouncer and any logic that consumes its state encoding.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_PENDING,
        PRESSED,
        RELEASE_PENDING
    } btn_state_t;

    // 10 ms and 0.5 s at the 16 MHz PLL clock.
    localparam int DEBOUNCE_10MS_16MHZ    = 160000;
    localparam int LONG_PRESS_500MS_16MHZ = 8000000;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pad inputs.
// RESET_VAL is the idle level of the pad, loaded while rst is high.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Next values: shift the pad level one stage per clock.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, reset to the idle pad level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw push-button pin into a clean level plus press, release
// and long-press pulses, and keeps a wrapping count of accepted presses.
module button_debounce
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEBOUNCE_10MS_16MHZ,
    parameter int LONG_PRESS_CYCLES = LONG_PRESS_500MS_16MHZ,
    parameter bit ACTIVE_LOW        = 1'b1
) (
    input  logic       clk_16mhz,
    input  logic       rst,
    input  logic       btn_pin,
    output logic       pressed,
    output logic       press,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam int STAB_W = $clog2(DEBOUNCE_CYCLES);
    localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic pin_sync;
    logic s;

    btn_state_t        state_q, state_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              pressed_q, pressed_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic [7:0]        count_q, count_d;

    logic [HOLD_W-1:0] hold_adv;
    logic              hold_hit;
    logic              stab_done;

    // The synchronizer idles at the released pin level so reset never
    // looks like a press.
    sync_2ff #(
        .RESET_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk_16mhz),
        .rst (rst),
        .d   (btn_pin),
        .q   (pin_sync)
    );

    assign s = pin_sync ^ ACTIVE_LOW;

    // Next state, counters and output pulses; pulses default low.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        hold_d    = hold_q;
        pressed_d = pressed_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        count_d   = count_q;

        hold_adv  = (hold_q != HOLD_MAX) ? hold_q + HOLD_W'(1) : hold_q;
        hold_hit  = (hold_q == HOLD_LAST);
        stab_done = (stab_q == STAB_LAST);

        unique case (state_q)
            RELEASED: begin
                if (s) begin
                    state_d = PRESS_PENDING;
                    stab_d  = '0;
                end
            end
            PRESS_PENDING: begin
                if (!s) begin
                    state_d = RELEASED;
                end else if (stab_done) begin
                    state_d   = PRESSED;
                    pressed_d = 1'b1;
                    press_d   = 1'b1;
                    count_d   = count_q + 8'd1;
                    hold_d    = '0;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            PRESSED: begin
                hold_d = hold_adv;
                long_d = hold_hit;
                if (!s) begin
                    state_d = RELEASE_PENDING;
                    stab_d  = '0;
                end
            end
            RELEASE_PENDING: begin
                if (s) begin
                    state_d = PRESSED;
                end else if (stab_done) begin
                    state_d   = RELEASED;
                    pressed_d = 1'b0;
                    release_d = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
                // An accepted release suppresses a coincident long press.
                if (s || !stab_done) begin
                    hold_d = hold_adv;
                    long_d = hold_hit;
                end
            end
            default: begin
                state_d = RELEASED;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_16mhz) begin
        if (rst) begin
            state_q   <= RELEASED;
            stab_q    <= '0;
            hold_q    <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            hold_q    <= hold_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            count_q   <= count_d;
        end
    end

    assign pressed       = pressed_q;
    assign press         = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign press_count   = count_q;

endmodule

// File: tb/tb_button_debounce.sv
// Self-checking bench for button_debounce: directed scenarios with literal
// expectations plus randomized pin activity against a run-length model.
module tb_button_debounce;

    localparam int D = 4;
    localparam int L = 20;
    localparam bit AL = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pin = 1'b1;
    logic       pressed;
    logic       press;
    logic       release_pulse;
    logic       long_press;
    logic [7:0] press_count;

    int tests = 0;
    int failed = 0;
    int n_press = 0;
    int n_rel = 0;
    int n_long = 0;

    button_debounce #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L),
        .ACTIVE_LOW        (AL)
    ) dut (
        .clk_16mhz     (clk),
        .rst           (rst),
        .btn_pin       (btn_pin),
        .pressed       (pressed),
        .press         (press),
        .release_pulse (release_pulse),
        .long_press    (long_press),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    // Reference model: the synchronized level must differ from the
    // debounced level for D+1 consecutive samples to be accepted.
    bit       p1, p2, sv;
    bit       lvl;
    int       run;
    int       age;
    bit       fired;
    bit       m_press, m_rel, m_long;
    bit       flip;
    logic [7:0] m_cnt;

    initial begin
        p1 = 0; p2 = 0; lvl = 0; run = 0; age = 0; fired = 0;
        m_press = 0; m_rel = 0; m_long = 0; m_cnt = 8'd0;
    end

    always @(posedge clk) begin
        if (rst) begin
            p1 = 0; p2 = 0; lvl = 0; run = 0; age = 0; fired = 0;
            m_press = 0; m_rel = 0; m_long = 0; m_cnt = 8'd0;
        end else begin
            sv = p2;
            p2 = p1;
            p1 = AL ? ~btn_pin : btn_pin;
            m_press = 0; m_rel = 0; m_long = 0; flip = 0;
            if (sv != lvl) begin
                run++;
                if (run == D + 1) begin
                    flip = 1;
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (flip) begin
                lvl = sv;
                if (lvl) begin
                    m_press = 1;
                    m_cnt = m_cnt + 8'd1;
                    age = 0;
                    fired = 0;
                end else begin
                    m_rel = 1;
                end
            end else if (lvl) begin
                if (age < L) age++;
                if (age == L && !fired) begin
                    m_long = 1;
                    fired = 1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus pulse bookkeeping.
    always @(posedge clk) begin
        #2;
        tests++;
        if (pressed !== lvl || press !== m_press ||
            release_pulse !== m_rel || long_press !== m_long ||
            press_count !== m_cnt) begin
            failed++;
            $display("FAIL model t=%0t got p=%b pr=%b rl=%b lp=%b c=%0d exp p=%b pr=%b rl=%b lp=%b c=%0d",
                     $time, pressed, press, release_pulse, long_press,
                     press_count, lvl, m_press, m_rel, m_long, m_cnt);
        end
        tests++;
        if ((int'(press === 1'b1) + int'(release_pulse === 1'b1) +
             int'(long_press === 1'b1)) > 1) begin
            failed++;
            $display("FAIL overlap t=%0t got pr=%b rl=%b lp=%b exp at most one",
                     $time, press, release_pulse, long_press);
        end
        if (press === 1'b1) n_press++;
        if (release_pulse === 1'b1) n_rel++;
        if (long_press === 1'b1) n_long++;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts rising edges until the selected pulse appears; -1 on timeout.
    task automatic edges_until(input int which, output int n);
        bit found;
        found = 0;
        n = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk);
            #2;
            n++;
            case (which)
                0: found = press;
                1: found = release_pulse;
                default: found = long_press;
            endcase
        end
        if (!found) n = -1;
    endtask

    int n, bp, br, bl;

    initial begin
        // Reset values.
        rst = 1; btn_pin = 1;
        cyc(3);
        check("reset_pressed", int'(pressed), 0);
        check("reset_press", int'(press), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_long", int'(long_press), 0);
        check("reset_count", int'(press_count), 0);
        rst = 0;
        cyc(5);

        // Clean press and long press.
        btn_pin = 0;
        edges_until(0, n);
        check("press_latency", n, 7);
        check("press_count_1", int'(press_count), 1);
        check("pressed_after", int'(pressed), 1);
        @(posedge clk); #2;
        check("press_one_cycle", int'(press), 0);
        edges_until(2, n);
        check("long_latency", n, L - 1);
        @(negedge clk);
        cyc(9);
        btn_pin = 1;
        edges_until(1, n);
        check("release_latency", n, 7);
        cyc(30);
        check("long_once", n_long, 1);
        check("released_level", int'(pressed), 0);

        // Bounce rejection.
        bp = n_press; br = n_rel; bl = n_long;
        btn_pin = 0; cyc(3);
        btn_pin = 1; cyc(2);
        btn_pin = 0; cyc(3);
        btn_pin = 1; cyc(20);
        check("bounce_press", n_press - bp, 0);
        check("bounce_release", n_rel - br, 0);
        check("bounce_pressed", int'(pressed), 0);
        check("bounce_count", int'(press_count), 1);

        // Count wrap.
        rst = 1; cyc(2); rst = 0; cyc(3);
        bp = n_press; br = n_rel;
        for (int i = 0; i < 256; i++) begin
            btn_pin = 0; cyc(10);
            btn_pin = 1; cyc(10);
        end
        check("wrap_count", int'(press_count), 0);
        check("wrap_presses", n_press - bp, 256);
        check("wrap_releases", n_rel - br, 256);

        // Randomized pin activity with occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1;
                cyc($urandom_range(1, 3));
                rst = 0;
            end
            btn_pin = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0)
                cyc($urandom_range(15, 30));
            else
                cyc($urandom_range(1, 8));
        end

        // Reset while held pressed.
        btn_pin = 1; cyc(15);
        rst = 1; cyc(2); rst = 0; cyc(2);
        btn_pin = 0;
        edges_until(0, n);
        check("pre_midreset_press", n, 7);
        @(negedge clk);
        rst = 1;
        @(posedge clk); #2;
        check("midreset_pressed", int'(pressed), 0);
        check("midreset_count", int'(press_count), 0);
        @(negedge clk);
        rst = 0;
        edges_until(0, n);
        check("after_reset_press", n, 7);
        check("after_reset_count", int'(press_count), 1);
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
